// File: rtl/demux_fifos.sv
// demux_fifos: routes each accepted word into one of NUM_REQS first-word-fall-through queues.
// Define DEMUX_BAD_DEST_EN for a sticky bad_dest flag on transfers to nonexistent queues.
module demux_fifos #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int DWID     = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [DWID-1:0]           dest,
  input  logic [WIDTH-1:0]          data_in,
  output logic                      ready,
  input  logic [NUM_REQS-1:0]       pop,
  output logic [NUM_REQS*WIDTH-1:0] flat_data_out,
  output logic [NUM_REQS-1:0]       empty,
  output logic [NUM_REQS-1:0]       full,
  output logic                      bad_dest
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic full_sel;
  // Out-of-range destinations match no queue, so they always see ready=1 and are dropped.
  always_comb begin
    full_sel = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) full_sel = full_sel | (full[i] & (dest == DWID'(i)));
  end
  assign ready = ~full_sel;
  for (genvar q = 0; q < NUM_REQS; q++) begin : g_q
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rp, wp;
    logic [CW-1:0]    cnt;
    logic             push, pull;
    assign push = valid & ready & (dest == DWID'(q));
    assign pull = pop[q] & ~empty[q];
    assign empty[q] = cnt == '0;
    assign full[q] = cnt == CW'(DEPTH);
    assign flat_data_out[q*WIDTH +: WIDTH] = empty[q] ? '0 : mem[rp];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rp  <= '0;
        wp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
        if (pull) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pull);
      end
    end
    always_ff @(posedge clk) begin
      if (push) mem[wp] <= data_in;
    end
  end
`ifdef DEMUX_BAD_DEST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bad_dest <= 1'b0;
    else if (valid & (32'(dest) >= NUM_REQS)) bad_dest <= 1'b1;
  end
`else
  assign bad_dest = 1'b0;
`endif
endmodule

// File: doc/demux_fifos.md
DEMUX_FIFOS -- requirements
Module: demux_fifos

Interface
REQ-001 Parameter NUM_REQS, default 4, SHALL set the number of destination queues (>= 2).
REQ-002 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-003 Parameter DEPTH, default 4, SHALL set the entries per queue (>= 2, not required to be a power of two).
REQ-004 Parameter DWID, default $clog2(NUM_REQS), SHALL set the destination field width.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 valid  input  1  SHALL mark the input word as offered.
REQ-008 dest  input  DWID  SHALL select the destination queue of the offered word.
REQ-009 data_in  input  WIDTH  SHALL carry the offered word.
REQ-010 ready  output  1  SHALL indicate the offered word is accepted this cycle.
REQ-011 pop  input  NUM_REQS  SHALL request removal of the head word of queue i (bit i).
REQ-012 flat_data_out  output  NUM_REQS*WIDTH  SHALL carry queue i's head word at bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-013 empty  output  NUM_REQS  SHALL be 1 when queue i holds 0 words.
REQ-014 full  output  NUM_REQS  SHALL be 1 when queue i holds DEPTH words.
REQ-015 bad_dest  output  1  SHALL flag a transfer to a nonexistent destination (see REQ-030).

Function
REQ-016 Transfer SHALL occur when valid & ready are both 1 on a rising clk edge.
REQ-017 ready SHALL be combinational: ~full[dest] for dest < NUM_REQS, 1 for dest >= NUM_REQS, independent of valid.
REQ-018 A same-cycle pop[dest] SHALL NOT raise ready on a full queue (no pass-through).
REQ-019 A transferred word SHALL be written to queue dest only; other queues SHALL be unchanged.
REQ-020 Each queue SHALL be first-word-fall-through: its head word appears on flat_data_out while empty[i]=0.
REQ-021 Latency: a word written into an empty queue SHALL be visible on flat_data_out, with empty[i]=0, one cycle after the accepting edge.
REQ-022 A queue slice SHALL drive 0 while empty[i]=1.
REQ-023 pop[i] while empty[i]=1 SHALL be ignored; no pointer or count change.
REQ-024 Simultaneous push and pop on a non-empty queue SHALL both occur; count unchanged, order preserved.
REQ-025 Simultaneous push and pop on an empty queue SHALL perform the push only.
REQ-026 Per-queue read/write pointers SHALL wrap from DEPTH-1 to 0; count SHALL be $clog2(DEPTH+1) bits, saturating never (guarded by full/empty).
REQ-027 Words SHALL leave each queue in strict arrival order.
REQ-028 full and empty SHALL be registered-count derived and update the cycle after the causing edge.

Reset
REQ-029 While rst=0: all pointers and counts SHALL be 0, empty=all 1s, full=0, flat_data_out=0, bad_dest=0; ready then equals 1 for any dest; reset mid-operation SHALL discard all stored words immediately.

Configuration
REQ-030 Macro DEMUX_BAD_DEST_EN defined: a transfer with dest >= NUM_REQS SHALL be discarded and bad_dest SHALL set the next cycle and stay 1 (sticky) until rst.
REQ-031 Macro DEMUX_BAD_DEST_EN undefined: such transfers SHALL be discarded silently and bad_dest SHALL be tied to 0.

Verification (NUM_REQS=4, WIDTH=8, DEPTH=4; NUM_REQS=3 for REQ-030 case)
REQ-032 Push 0xA1,0xA2 to dest 2, no pops -> next cycles empty=4'b1011, slice 2 = 0xA1; pop[2] -> slice 2 = 0xA2.
REQ-033 Push 4 words to dest 1 -> full[1]=1; 5th offer to dest 1 with pop[1]=1 -> ready=0, after edge count 3, full[1]=0.
REQ-034 Empty queue 0, push 0x55 with pop[0]=1 same cycle -> after edge empty[0]=0, slice 0 = 0x55.
REQ-035 Fill queue 3, pop 2, push 2 more (pointer wrap) -> pops return exact arrival order.
REQ-036 NUM_REQS=3, valid=1, dest=3 -> ready=1, no queue changes; bad_dest=1 next cycle with macro, 0 without.
REQ-037 Queues 0 and 2 loaded, assert rst=0 asynchronously mid-cycle -> empty=4'b1111, flat_data_out=0 before next edge.
